// File: rtl/maze_grid_memory.sv
// Maze cell store: 2^X_W x 2^Y_W grid with a self-clearing sweep after reset or clr.
// Define MAZE_NEIGHBOR_EN to add the walls_nesw neighbour-wall read port.
module maze_grid_memory #(
   parameter int X_W    = 4,
   parameter int Y_W    = 4,
   parameter int CELL_W = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              rd,
   input  logic              wr,
   input  logic [X_W-1:0]    x_pos,
   input  logic [Y_W-1:0]    y_pos,
   input  logic [CELL_W-1:0] data_in,
   output logic [CELL_W-1:0] data_out,
   output logic              rd_valid,
   output logic              busy,
   output logic              clr_done,
`ifdef MAZE_NEIGHBOR_EN
   output logic [3:0]        walls_nesw,
`endif
   output logic              req_drop
);

   localparam int A_W   = X_W + Y_W;
   localparam int DEPTH = 1 << A_W;
   localparam logic [A_W-1:0] LAST = '1;

   typedef enum logic {
      SWEEP,
      IDLE
   } state_e;

   state_e            state_q, state_d;
   logic [A_W-1:0]    cnt_q, cnt_d;
   logic [CELL_W-1:0] mem [DEPTH];

   logic [CELL_W-1:0] data_out_q, data_out_d;
   logic              rd_valid_q, rd_valid_d;
   logic              req_drop_q, req_drop_d;

   logic [A_W-1:0]    addr;
   logic              rdSrv;
   logic              wrSrv;

   assign addr  = {y_pos, x_pos};
   assign rdSrv = (state_q == IDLE) && rd;
   assign wrSrv = (state_q == IDLE) && wr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SWEEP;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A clr during a sweep restarts it; completion only happens on an uninterrupted last cell.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         SWEEP: begin
            if (clr) begin
               cnt_d = '0;
            end else if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         IDLE: begin
            if (clr) begin
               state_d = SWEEP;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = SWEEP;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      busy     = (state_q == SWEEP);
      clr_done = (state_q == SWEEP) && (cnt_q == LAST) && !clr;
   end

   // Array has no reset; the sweep is what clears it.
   always_ff @(posedge clk) begin
      if (state_q == SWEEP) begin
         mem[cnt_q] <= '0;
      end else if (wrSrv) begin
         mem[addr] <= data_in;
      end
   end

   always_comb begin
      rd_valid_d = rdSrv;
      data_out_d = rdSrv ? mem[addr] : data_out_q;
      req_drop_d = (state_q == SWEEP) && (rd || wr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
         req_drop_q <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         rd_valid_q <= rd_valid_d;
         req_drop_q <= req_drop_d;
      end
   end

   assign data_out = data_out_q;
   assign rd_valid = rd_valid_q;
   assign req_drop = req_drop_q;

`ifdef MAZE_NEIGHBOR_EN
   logic [3:0]     walls_q, walls_d;
   logic [3:0]     nbr;
   logic [X_W-1:0] xMinus, xPlus;
   logic [Y_W-1:0] yMinus, yPlus;

   assign xMinus = x_pos - X_W'(1);
   assign xPlus  = x_pos + X_W'(1);
   assign yMinus = y_pos - Y_W'(1);
   assign yPlus  = y_pos + Y_W'(1);

   // Bit order is N,E,S,W from bit 0; cells beyond the grid edge count as walls.
   always_comb begin
      nbr[0]  = (y_pos == '0) ? 1'b1 : mem[{yMinus, x_pos}][0];
      nbr[1]  = (x_pos == '1) ? 1'b1 : mem[{y_pos, xPlus}][0];
      nbr[2]  = (y_pos == '1) ? 1'b1 : mem[{yPlus, x_pos}][0];
      nbr[3]  = (x_pos == '0) ? 1'b1 : mem[{y_pos, xMinus}][0];
      walls_d = rdSrv ? nbr : walls_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         walls_q <= '0;
      end else begin
         walls_q <= walls_d;
      end
   end

   assign walls_nesw = walls_q;
`endif

endmodule

// File: tb/tb_maze_grid_memory.sv
// Self-checking bench for maze_grid_memory: vector table plus reset, drop and sweep sequences.
// Neighbour checks are included when MAZE_NEIGHBOR_EN is defined.
module tb_maze_grid_memory;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       rd = 1'b0;
   logic       wr = 1'b0;
   logic [3:0] x_pos = '0;
   logic [3:0] y_pos = '0;
   logic [0:0] data_in = '0;
   logic [0:0] data_out;
   logic       rd_valid, busy, clr_done, req_drop;
`ifdef MAZE_NEIGHBOR_EN
   logic [3:0] walls_nesw;
`endif

   maze_grid_memory #(.X_W(4), .Y_W(4), .CELL_W(1)) dut (
      .clk(clk), .rst(rst), .clr(clr), .rd(rd), .wr(wr),
      .x_pos(x_pos), .y_pos(y_pos), .data_in(data_in),
      .data_out(data_out), .rd_valid(rd_valid), .busy(busy),
      .clr_done(clr_done),
`ifdef MAZE_NEIGHBOR_EN
      .walls_nesw(walls_nesw),
`endif
      .req_drop(req_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rd;
      logic       wr;
      logic       clr;
      logic [3:0] x;
      logic [3:0] y;
      logic       din;
      logic       expData;
      logic [3:0] expWalls;
      logic       chkWalls;
   } vec_t;

   typedef struct {
      logic       data;
      logic [3:0] walls;
      logic       chk;
   } exp_t;

   exp_t sbQ[$];
   int   checks = 0;
   int   errors = 0;
   bit   mBusy = 1'b1;
   int   mCnt = 0;
   bit   prevRd = 1'b0;
   bit   prevDrop = 1'b0;
   logic lastData = 1'b0;
   int   doneCount = 0;
   int   busyCount = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic w, input logic c,
                               input logic [3:0] x, input logic [3:0] y,
                               input logic d, input logic e);
      vec_t v;
      v.rd = r; v.wr = w; v.clr = c; v.x = x; v.y = y; v.din = d;
      v.expData = e; v.expWalls = 4'b0000; v.chkWalls = 1'b0;
      return v;
   endfunction

   // Samples the current cycle against the cycle model and the read scoreboard.
   task automatic checkOutput(input logic clrIn);
      exp_t e;
      check("busy", busy, mBusy);
      check("clr_done", clr_done, mBusy && (mCnt == 255) && !clrIn);
      check("req_drop", req_drop, prevDrop);
      check("rd_valid", rd_valid, prevRd);
      if (prevRd) begin
         e = sbQ.pop_front();
         check("data_out", data_out, e.data);
         lastData = e.data;
`ifdef MAZE_NEIGHBOR_EN
         if (e.chk) check("walls_nesw", walls_nesw, e.walls);
`endif
      end else begin
         check("data_hold", data_out, lastData);
      end
      if (clr_done) doneCount++;
      if (busy) busyCount++;
   endtask

   // Called at posedge+1; drives one cycle and advances the model across the next edge.
   task automatic applyStimulus(input vec_t v);
      rd = v.rd; wr = v.wr; clr = v.clr; x_pos = v.x; y_pos = v.y; data_in = v.din;
      #3;
      checkOutput(v.clr);
      prevDrop = mBusy && (v.rd || v.wr);
      prevRd   = !mBusy && v.rd;
      if (prevRd) sbQ.push_back('{data: v.expData, walls: v.expWalls, chk: v.chkWalls});
      if (mBusy) begin
         if (v.clr) mCnt = 0;
         else if (mCnt == 255) begin mBusy = 1'b0; mCnt = 0; end
         else mCnt++;
      end else if (v.clr) begin
         mBusy = 1'b1;
         mCnt  = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(mk(0, 0, 0, 4'd0, 4'd0, 0, 0));
   endtask

   task automatic applyReset();
      rst = 1'b0; rd = 1'b1; wr = 1'b0; clr = 1'b0;
      #3;
      check("rst_data_out", data_out, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_clr_done", clr_done, 0);
      check("rst_req_drop", req_drop, 0);
      check("rst_busy", busy, 1);
      rd = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      mBusy = 1'b1; mCnt = 0; prevRd = 1'b0; prevDrop = 1'b0; lastData = 1'b0;
      sbQ.delete();
   endtask

   task automatic runSweep(input string tag);
      int guard = 0;
      doneCount = 0;
      busyCount = 0;
      while (mBusy && guard < 400) begin
         idle();
         guard++;
      end
      idle();
      check({tag, "_busy_cycles"}, busyCount, 256);
      check({tag, "_done_pulses"}, doneCount, 1);
   endtask

   vec_t vecs[12];

   initial begin
      vecs[0]  = mk(0, 1, 0, 4'd1,  4'd0,  1, 0);
      vecs[1]  = mk(1, 0, 0, 4'd1,  4'd0,  0, 1);
      vecs[2]  = mk(1, 0, 0, 4'd1,  4'd1,  0, 0);
      vecs[3]  = mk(1, 1, 0, 4'd3,  4'd3,  1, 0);
      vecs[4]  = mk(1, 0, 0, 4'd3,  4'd3,  0, 1);
      vecs[5]  = mk(0, 1, 0, 4'd15, 4'd15, 1, 0);
      vecs[6]  = mk(1, 0, 0, 4'd15, 4'd15, 0, 1);
      vecs[7]  = mk(1, 0, 0, 4'd0,  4'd0,  0, 0);
      vecs[8]  = mk(1, 1, 0, 4'd15, 4'd15, 0, 1);
      vecs[9]  = mk(1, 0, 0, 4'd15, 4'd15, 0, 0);
      vecs[10] = mk(0, 1, 0, 4'd7,  4'd9,  1, 0);
      vecs[11] = mk(1, 0, 0, 4'd7,  4'd9,  0, 1);

      #1;
      applyReset();
      runSweep("por");

      for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);
      repeat (2) idle();

      // clr with a same-cycle read, then dropped accesses during the sweep
      applyStimulus(mk(1, 0, 1, 4'd1, 4'd0, 0, 1));
      applyStimulus(mk(0, 1, 0, 4'd2, 4'd2, 1, 0));
      applyStimulus(mk(1, 0, 0, 4'd1, 4'd0, 0, 0));
      repeat (40) idle();
      applyStimulus(mk(0, 0, 1, 4'd0, 4'd0, 0, 0));
      runSweep("clr");
      applyStimulus(mk(1, 0, 0, 4'd2, 4'd2, 0, 0));
      applyStimulus(mk(1, 0, 0, 4'd1, 4'd0, 0, 0));
      applyStimulus(mk(1, 0, 0, 4'd7, 4'd9, 0, 0));
      idle();

      // reset at sweep cycle 100 must restart a full sweep
      applyStimulus(mk(0, 1, 0, 4'd15, 4'd15, 1, 0));
      applyStimulus(mk(0, 1, 0, 4'd4,  4'd2,  1, 0));
      applyStimulus(mk(0, 0, 1, 4'd0, 4'd0, 0, 0));
      repeat (100) idle();
      applyReset();
      runSweep("mid");
      for (int i = 0; i < 256; i++) begin
         applyStimulus(mk(1, 0, 0, 4'(i % 16), 4'(i / 16), 0, 0));
      end
      idle();

`ifdef MAZE_NEIGHBOR_EN
      begin
         vec_t v;
         applyStimulus(mk(0, 1, 0, 4'd5, 4'd4, 1, 0));
         applyStimulus(mk(0, 1, 0, 4'd6, 4'd5, 1, 0));
         v = mk(1, 0, 0, 4'd5, 4'd5, 0, 0);
         v.expWalls = 4'b0011; v.chkWalls = 1'b1;
         applyStimulus(v);
         v = mk(1, 0, 0, 4'd0, 4'd0, 0, 0);
         v.expWalls = 4'b1001; v.chkWalls = 1'b1;
         applyStimulus(v);
         idle();
      end
`endif

      check("sb_drained", sbQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
